btb_bimodal_predictor: RTL and testbench
========================================

// Module: btb_bimodal_predictor
// PURPOSE
//  Parametrised, direct-mapped branch target buffer with a per-entry valid bit and a
//  CNT_W-bit saturating direction counter. Sits in the IF stage: combinational lookup
//  of the fetch PC gives hit, predicted direction and target; EX-stage branch
//  resolution trains it one cycle later through a registered update port. Adds a
//  multi-cycle invalidate walk, used on context switch or self-modifying code.
// PARAMETERS
//  PC_W     32   PC and target width
//  ENTRIES  32   entry count; power of two, >= 2
//  CNT_W    2    direction counter width; taken when counter MSB = 1
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high
//  lookup_pc      in   PC_W    fetch PC
//  lookup_hit     out  1       valid entry with matching tag (forced 0 while busy)
//  pred_taken     out  1       lookup_hit & counter MSB
//  pred_target    out  PC_W    stored target on hit, else 0
//  upd_valid      in   1       resolved-branch update strobe
//  upd_pc         in   PC_W    PC of resolved branch
//  upd_taken      in   1       actual direction
//  upd_target     in   PC_W    actual target
//  clear_req      in   1       start invalidate walk (pulse)
//  busy           out  1       invalidate walk in progress
// BEHAVIOUR
//  - IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]; pc[1:0] ignored.
//  - Lookup is purely combinational off the state registers; zero-cycle latency.
//  - Reset (async): all valid = 0, counters = 01 (weakly not-taken; for CNT_W>2 MSB=0,
//    other bits 1), tags/targets = 0, FSM = IDLE. So lookup_hit, pred_taken,
//    pred_target and busy all read 0.
//  - Update, applied at the posedge when upd_valid=1 and FSM=IDLE:
//    * hit (valid & tag match): counter +1 if taken, -1 if not; saturates at all-ones/0.
//      Target is overwritten only when taken.
//    * miss & taken: allocate. Tag and target are written, valid=1, counter = 10
//      (weakly taken; MSB=1, rest 0). Any previous occupant is evicted.
//    * miss & not-taken: no state change.
//  - Lookup and update in the same cycle, same index: lookup returns pre-update state
//    (no bypass). The new state is visible the next cycle.
//  - FSM IDLE/CLEAR:
//    * IDLE + clear_req -> CLEAR, ptr=0.
//    * In CLEAR, each cycle: valid[ptr]=0, counter[ptr]=reset value, ptr++.
//    * ptr==ENTRIES-1 -> IDLE after clearing that entry. The walk takes exactly ENTRIES cycles.
//    * busy=1 in CLEAR. Lookups miss and updates are dropped while busy.
//      clear_req while busy is ignored.
//    * clear_req and upd_valid in the same IDLE cycle: the clear wins and the update is dropped.
//  - Reset mid-walk: immediate return to IDLE with all entries invalid.
//  - Counter arithmetic is CNT_W-bit unsigned with explicit saturation checks; no wrap.
// STRUCTURE
//  - Package btb_pkg: state enum {IDLE, CLEAR}; functions/localparams CNT_RESET,
//    CNT_ALLOC, CNT_MAX; clog2 helper for IDX_W.
//  - Sub-module btb_sat_counter: next-value logic (cnt, inc, dec -> cnt_next),
//    parametrised by CNT_W, instantiated once on the update path.
//  - Arrays: tag[ENTRIES], target[ENTRIES], cnt[ENTRIES], valid[ENTRIES] as flops,
//    written only in the single clocked process.
// TESTING
//  1 Reset then lookup 0x0000_0040 -> hit=0, taken=0, target=0, busy=0.
//  2 Update pc=0x40 taken tgt=0x100; next cycle lookup 0x40 -> hit=1, taken=1 (cnt=10),
//    target=0x100. Lookup 0x1040 (same index, other tag) -> hit=0.
//  3 Three not-taken updates to 0x40 -> cnt 10->01->00->00, taken=0, hit=1, target still 0x100.
//    Then two taken updates -> 01->10, taken=1.
//  4 Update pc=0x80 not-taken on empty entry -> lookup 0x80 hit=0. Same-cycle update
//    0x40 tgt=0x200 with lookup 0x40 -> old target 0x100; next cycle 0x200.
//  5 Fill 4 entries, pulse clear_req -> busy=1 for exactly ENTRIES cycles. Lookups miss
//    throughout; an update issued mid-walk is dropped; afterwards all lookups miss.
//  6 Assert reset at walk cycle 5 -> busy=0 immediately, all miss. Also run with
//    ENTRIES=8, CNT_W=3 and check saturation at 111 and index aliasing at stride 0x20.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the bimodal branch target buffer.
package btb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Ceiling log2, used to size the index field from the entry count.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Weakly not-taken: MSB clear, all lower bits set.
    function automatic int cnt_reset(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    // Weakly taken: MSB set, all lower bits clear.
    function automatic int cnt_alloc(input int w);
        return 1 << (w - 1);
    endfunction

    // Saturation ceiling: all ones.
    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/btb_bimodal_predictor_if.sv
// Lookup, update and invalidate signals between the fetch/execute stages and the BTB.
interface btb_bimodal_predictor_if #(
    parameter int PC_W = 32
);
    logic            lookup_valid_unused_placeholder_n;
    logic [PC_W-1:0] lookup_pc;
    logic            lookup_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic [PC_W-1:0] upd_target;
    logic            clear_req;
    logic            busy;

    // Pipeline side: issues lookups, updates and clear requests.
    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, clear_req,
        input  lookup_hit, pred_taken, pred_target, busy
    );

    // Predictor side.
    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, clear_req,
        output lookup_hit, pred_taken, pred_target, busy
    );
endinterface

// File: rtl/btb_sat_counter.sv
// Next-value logic for an up/down saturating direction counter.
module btb_sat_counter
    import btb_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic [CNT_W-1:0] cnt,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt_next
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    // Step toward the requested direction, holding at either rail instead of wrapping.
    always_comb begin
        // NOTE: default assignment first so every path drives cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (inc && !dec && cnt != CNT_MAX)
            cnt_next = cnt + CNT_W'(1);
        else if (dec && !inc && cnt != '0)
            cnt_next = cnt - CNT_W'(1);
    end
endmodule

// File: rtl/btb_bimodal_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and an
// entry-by-entry invalidate walk.
module btb_bimodal_predictor
    import btb_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int ENTRIES = 32,
    parameter int CNT_W   = 2
) (
    input logic                    clk,
    input logic                    reset,
    btb_bimodal_predictor_if.slave bus
);
    localparam int                 IDX_W    = clog2(ENTRIES);
    localparam int                 TAG_W    = PC_W - IDX_W - 2;
    localparam logic [CNT_W-1:0]   CNT_RST  = CNT_W'(cnt_reset(CNT_W));
    localparam logic [CNT_W-1:0]   CNT_ALC  = CNT_W'(cnt_alloc(CNT_W));
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(ENTRIES - 1);

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit, up_hit;
    logic [CNT_W-1:0]   up_cnt_next;
    logic               unused_pc_bits;

    // Byte-offset bits never select an entry.
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[PC_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[PC_W-1:IDX_W+2];

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign lk_hit = (state == IDLE) && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    // Lookup reads pre-update state: no bypass from the update port.
    assign bus.lookup_hit  = lk_hit;
    assign bus.pred_taken  = lk_hit && cnt_q[lk_idx][CNT_W-1];
    assign bus.pred_target = lk_hit ? target_q[lk_idx] : '0;
    assign bus.busy        = (state == CLEAR);

    btb_sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .cnt      (cnt_q[up_idx]),
        .inc      (bus.upd_taken),
        .dec      (!bus.upd_taken),
        .cnt_next (up_cnt_next)
    );

    // Single owner of all predictor state: reset, invalidate walk and training.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            // NOTE: the entry arrays are real flops with a reset, so a freshly reset
            // predictor never hits on stale tags; this is not an inferred RAM.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_RST;
            end
        end else begin
            // NOTE: non-blocking assignments throughout, so every read in this block
            // sees the pre-edge value regardless of statement order.
            case (state)
                IDLE: begin
                    if (bus.clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end else if (bus.upd_valid) begin
                        if (up_hit) begin
                            cnt_q[up_idx] <= up_cnt_next;
                            if (bus.upd_taken)
                                target_q[up_idx] <= bus.upd_target;
                        end else if (bus.upd_taken) begin
                            valid_q[up_idx]  <= 1'b1;
                            tag_q[up_idx]    <= up_tag;
                            target_q[up_idx] <= bus.upd_target;
                            cnt_q[up_idx]    <= CNT_ALC;
                        end
                    end
                end
                CLEAR: begin
                    valid_q[ptr] <= 1'b0;
                    cnt_q[ptr]   <= CNT_RST;
                    ptr          <= ptr + IDX_W'(1);
                    if (ptr == LAST_IDX)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_btb_bimodal_predictor.sv
// Self-checking bench: two predictor configurations against a table-level model.
module tb_btb_bimodal_predictor;
    logic clk = 1'b0;
    logic rst0, rst1;
    always #5 clk = ~clk;

    btb_bimodal_predictor_if #(.PC_W(32)) b0 ();
    btb_bimodal_predictor_if #(.PC_W(32)) b1 ();

    btb_bimodal_predictor #(.PC_W(32), .ENTRIES(32), .CNT_W(2)) dut0 (
        .clk(clk), .reset(rst0), .bus(b0));
    btb_bimodal_predictor #(.PC_W(32), .ENTRIES(8), .CNT_W(3)) dut1 (
        .clk(clk), .reset(rst1), .bus(b1));

    int checks = 0;
    int errors = 0;

    // Reference model: one table per configuration, plain integers.
    bit          m_valid [2][32];
    int unsigned m_tag   [2][32];
    logic [31:0] m_tgt   [2][32];
    int          m_cnt   [2][32];
    int          walk_left [2];
    int          walk_pos  [2];

    // Stimulus shadows, copied onto the interfaces by apply().
    logic [31:0] s_lpc [2];
    logic [31:0] s_upc [2];
    logic [31:0] s_utgt[2];
    bit          s_uv  [2];
    bit          s_ut  [2];
    bit          s_clr [2];

    function automatic int n_ent(int c);  return (c == 1) ? 8 : 32; endfunction
    function automatic int n_idxw(int c); return (c == 1) ? 3 : 5;  endfunction
    function automatic int n_cw(int c);   return (c == 1) ? 3 : 2;  endfunction
    function automatic int idx_of(int c, logic [31:0] pc);
        return int'((pc >> 2) % 32'(n_ent(c)));
    endfunction
    function automatic int unsigned tag_of(int c, logic [31:0] pc);
        return pc >> (n_idxw(c) + 2);
    endfunction

    task automatic model_reset(int c);
        for (int i = 0; i < 32; i++) begin
            m_valid[c][i] = 1'b0;
            m_tag[c][i]   = 0;
            m_tgt[c][i]   = '0;
            m_cnt[c][i]   = (2 ** (n_cw(c) - 1)) - 1;
        end
        walk_left[c] = 0;
        walk_pos[c]  = 0;
    endtask

    task automatic model_clock(int c);
        int i, mx;
        mx = (2 ** n_cw(c)) - 1;
        if (walk_left[c] > 0) begin
            m_valid[c][walk_pos[c]] = 1'b0;
            m_cnt[c][walk_pos[c]]   = (2 ** (n_cw(c) - 1)) - 1;
            walk_pos[c]++;
            walk_left[c]--;
        end else if (s_clr[c]) begin
            walk_left[c] = n_ent(c);
            walk_pos[c]  = 0;
        end else if (s_uv[c]) begin
            i = idx_of(c, s_upc[c]);
            if (m_valid[c][i] && m_tag[c][i] == tag_of(c, s_upc[c])) begin
                if (s_ut[c]) begin
                    m_cnt[c][i] = (m_cnt[c][i] < mx) ? m_cnt[c][i] + 1 : mx;
                    m_tgt[c][i] = s_utgt[c];
                end else begin
                    m_cnt[c][i] = (m_cnt[c][i] > 0) ? m_cnt[c][i] - 1 : 0;
                end
            end else if (s_ut[c]) begin
                m_valid[c][i] = 1'b1;
                m_tag[c][i]   = tag_of(c, s_upc[c]);
                m_tgt[c][i]   = s_utgt[c];
                m_cnt[c][i]   = 2 ** (n_cw(c) - 1);
            end
        end
    endtask

    task automatic apply();
        b0.lookup_pc = s_lpc[0]; b0.upd_valid = s_uv[0]; b0.upd_pc = s_upc[0];
        b0.upd_taken = s_ut[0];  b0.upd_target = s_utgt[0]; b0.clear_req = s_clr[0];
        b1.lookup_pc = s_lpc[1]; b1.upd_valid = s_uv[1]; b1.upd_pc = s_upc[1];
        b1.upd_taken = s_ut[1];  b1.upd_target = s_utgt[1]; b1.clear_req = s_clr[1];
    endtask

    task automatic chk(string nm, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, exp);
        end
    endtask

    // Drive a lookup PC, let it settle, compare all outputs with the model.
    task automatic look(int c, string nm, logic [31:0] pc);
        int i;
        bit hit, tk;
        logic [31:0] tg;
        logic h_o, t_o, b_o;
        logic [31:0] g_o;
        s_lpc[c] = pc;
        apply();
        #1;
        i   = idx_of(c, pc);
        hit = (walk_left[c] == 0) && m_valid[c][i] && (m_tag[c][i] == tag_of(c, pc));
        tk  = hit && (m_cnt[c][i] >= 2 ** (n_cw(c) - 1));
        tg  = hit ? m_tgt[c][i] : 32'h0;
        h_o = (c == 1) ? b1.lookup_hit  : b0.lookup_hit;
        t_o = (c == 1) ? b1.pred_taken  : b0.pred_taken;
        g_o = (c == 1) ? b1.pred_target : b0.pred_target;
        b_o = (c == 1) ? b1.busy        : b0.busy;
        chk({nm, "_hit"},    32'(h_o), 32'(hit));
        chk({nm, "_taken"},  32'(t_o), 32'(tk));
        chk({nm, "_target"}, g_o, tg);
        chk({nm, "_busy"},   32'(b_o), 32'(walk_left[c] > 0));
    endtask

    // One clock: model follows the posedge, strobes drop at the next negedge.
    task automatic tick();
        @(posedge clk);
        if (!rst0) model_clock(0);
        if (!rst1) model_clock(1);
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            s_uv[c]  = 1'b0;
            s_clr[c] = 1'b0;
        end
        apply();
    endtask

    task automatic upd(int c, logic [31:0] pc, bit tk, logic [31:0] tgt);
        s_uv[c] = 1'b1; s_upc[c] = pc; s_ut[c] = tk; s_utgt[c] = tgt;
        apply();
    endtask

    int n;
    logic [31:0] pc_r;

    initial begin
        for (int c = 0; c < 2; c++) begin
            s_lpc[c] = '0; s_upc[c] = '0; s_utgt[c] = '0;
            s_uv[c] = 1'b0; s_ut[c] = 1'b0; s_clr[c] = 1'b0;
            model_reset(c);
        end
        apply();
        rst0 = 1'b1;
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // 1: reset state
        look(0, "t1", 32'h40);
        chk("t1_hit_const", 32'(b0.lookup_hit), 32'h0);

        // 2: allocate on taken, then alias miss
        upd(0, 32'h40, 1'b1, 32'h100);
        tick();
        look(0, "t2_hit", 32'h40);
        chk("t2_target_const", b0.pred_target, 32'h100);
        chk("t2_taken_const", 32'(b0.pred_taken), 32'h1);
        look(0, "t2_alias", 32'h1040);
        chk("t2_alias_const", 32'(b0.lookup_hit), 32'h0);

        // 3: walk the counter down to saturation and back
        for (int k = 0; k < 3; k++) begin
            upd(0, 32'h40, 1'b0, 32'hdead);
            tick();
            look(0, "t3_down", 32'h40);
        end
        chk("t3_floor_taken", 32'(b0.pred_taken), 32'h0);
        chk("t3_keep_target", b0.pred_target, 32'h100);
        for (int k = 0; k < 2; k++) begin
            upd(0, 32'h40, 1'b1, 32'h100);
            tick();
            look(0, "t3_up", 32'h40);
        end
        chk("t3_retaken", 32'(b0.pred_taken), 32'h1);

        // 4: not-taken miss allocates nothing; same-cycle update is not bypassed
        upd(0, 32'h80, 1'b0, 32'h999);
        tick();
        look(0, "t4_nt_miss", 32'h80);
        upd(0, 32'h40, 1'b1, 32'h200);
        look(0, "t4_same_cycle", 32'h40);
        chk("t4_old_target", b0.pred_target, 32'h100);
        tick();
        look(0, "t4_new", 32'h40);
        chk("t4_new_target", b0.pred_target, 32'h200);

        // 5: fill, clear walk with an ignored re-request and a dropped update
        for (int k = 0; k < 4; k++) begin
            upd(0, 32'(k * 4), 1'b1, 32'h1000 + 32'(k));
            tick();
        end
        look(0, "t5_filled", 32'h8);
        s_clr[0] = 1'b1;
        upd(0, 32'hC0, 1'b1, 32'h777);
        look(0, "t5_issue", 32'h4);
        tick();
        n = 0;
        for (int k = 0; k < 40 && b0.busy === 1'b1; k++) begin
            n++;
            if (k == 3) s_clr[0] = 1'b1;
            if (k == 10) upd(0, 32'h44, 1'b1, 32'h300);
            look(0, "t5_walk", 32'(4 * (k % 4)));
            tick();
        end
        chk("t5_walk_len", 32'(n), 32'd32);
        for (int k = 0; k < 4; k++) look(0, "t5_after", 32'(k * 4));
        tick();
        look(0, "t5_drop", 32'h44);
        look(0, "t5_clr_wins", 32'hC0);
        look(0, "t5_old40", 32'h40);

        // 6: reset in the middle of a walk
        for (int k = 0; k < 4; k++) begin
            upd(0, 32'(k * 4), 1'b1, 32'h2000 + 32'(k));
            tick();
        end
        s_clr[0] = 1'b1;
        apply();
        tick();
        repeat (4) tick();
        chk("t6_busy_before", 32'(b0.busy), 32'h1);
        rst0 = 1'b1;
        model_reset(0);
        look(0, "t6_rst", 32'h4);
        chk("t6_busy_const", 32'(b0.busy), 32'h0);
        tick();
        rst0 = 1'b0;
        for (int k = 0; k < 4; k++) look(0, "t6_after", 32'(k * 4));
        tick();

        // Small configuration: aliasing at stride 0x20 and 3-bit saturation
        upd(1, 32'h40, 1'b1, 32'h500);
        tick();
        look(1, "s_alloc", 32'h40);
        look(1, "s_alias_miss", 32'h60);
        upd(1, 32'h60, 1'b1, 32'h600);
        tick();
        look(1, "s_evicted", 32'h40);
        chk("s_evict_const", 32'(b1.lookup_hit), 32'h0);
        look(1, "s_new", 32'h60);
        for (int k = 0; k < 5; k++) begin
            upd(1, 32'h60, 1'b1, 32'h600);
            tick();
        end
        look(1, "s_sat", 32'h60);
        for (int k = 0; k < 3; k++) begin
            upd(1, 32'h60, 1'b0, 32'h0);
            tick();
        end
        look(1, "s_down3", 32'h60);
        chk("s_still_taken", 32'(b1.pred_taken), 32'h1);
        upd(1, 32'h60, 1'b0, 32'h0);
        tick();
        look(1, "s_down4", 32'h60);
        chk("s_now_nt", 32'(b1.pred_taken), 32'h0);

        // Randomized traffic on both configurations
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < 2; c++) begin
                pc_r = ($urandom_range(0, 2) << (n_idxw(c) + 2))
                     | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
                s_uv[c]   = ($urandom_range(0, 3) != 0);
                s_upc[c]  = pc_r;
                s_ut[c]   = $urandom_range(0, 1) != 0;
                s_utgt[c] = $urandom;
                s_clr[c]  = ($urandom_range(0, 59) == 0);
                pc_r = ($urandom_range(0, 2) << (n_idxw(c) + 2))
                     | ($urandom_range(0, 3) << 2);
                look(c, "rnd", pc_r);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
